// File: rtl/pc_sequencer_if.sv
// Control/status bundle for the pc_sequencer: run/step/branch inputs from the
// controller, phase strobes, program counter and status back from the sequencer.
interface pc_sequencer_if;
   logic        RUN;
   logic        STEP;
   logic        HALT_REQ;
   logic        JUMP_EN;
   logic [7:0]  JUMP_ADDR;
   logic        PH_FT;
   logic        PH_DC;
   logic        PH_EX;
   logic        PH_WB;
   logic [7:0]  P_COUNT;
   logic        RUNNING;
   logic        HALTED;
   logic [15:0] RETIRED;

   modport master (
      output RUN, STEP, HALT_REQ, JUMP_EN, JUMP_ADDR,
      input  PH_FT, PH_DC, PH_EX, PH_WB, P_COUNT, RUNNING, HALTED, RETIRED
   );

   modport slave (
      input  RUN, STEP, HALT_REQ, JUMP_EN, JUMP_ADDR,
      output PH_FT, PH_DC, PH_EX, PH_WB, P_COUNT, RUNNING, HALTED, RETIRED
   );
endinterface

// File: rtl/pc_sequencer.sv
// Four-phase instruction sequencer (FT/DC/EX/WB) with free-run, single-step,
// branch and sticky halt; owns the program counter and a retired-instruction count.
module pc_sequencer (
   input logic         CLK,
   input logic         RESET_N,
   pc_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_FT   = 3'd1,
      S_DC   = 3'd2,
      S_EX   = 3'd3,
      S_WB   = 3'd4
   } state_t;

   state_t      state_r;
   state_t      next_state_s;
   logic [3:0]  phase_r;
   logic [7:0]  pc_r;
   logic        running_r;
   logic        halted_r;
   logic [15:0] retired_r;
   logic        halt_lat_r;
   logic        jump_lat_r;
   logic [7:0]  jaddr_lat_r;
   logic        step_mode_r;
   logic        prev_run_r;
   logic        run_rise_s;
   logic        start_s;

   function automatic logic [3:0] phase_of(input state_t s);
      case (s)
         S_FT:    phase_of = 4'b0001;
         S_DC:    phase_of = 4'b0010;
         S_EX:    phase_of = 4'b0100;
         S_WB:    phase_of = 4'b1000;
         default: phase_of = 4'b0000;
      endcase
   endfunction

   // Start condition and next-state selection
   always_comb begin
      run_rise_s   = bus.RUN & ~prev_run_r;
      // once halted, only a fresh RUN edge may restart; level RUN and STEP are ignored
      start_s      = halted_r ? run_rise_s : (bus.RUN | bus.STEP);
      next_state_s = S_IDLE;
      case (state_r)
         S_IDLE: begin
            if (start_s) next_state_s = S_FT;
            else         next_state_s = S_IDLE;
         end
         S_FT: next_state_s = S_DC;
         S_DC: next_state_s = S_EX;
         S_EX: next_state_s = S_WB;
         S_WB: begin
            if (halt_lat_r || step_mode_r) next_state_s = S_IDLE;
            else if (bus.RUN)              next_state_s = S_FT;
            else                           next_state_s = S_IDLE;
         end
         default: next_state_s = S_IDLE;
      endcase
   end

   // Sequencer state, registered strobes, PC/retire bookkeeping
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r     <= S_IDLE;
         phase_r     <= 4'b0000;
         pc_r        <= 8'h00;
         running_r   <= 1'b0;
         halted_r    <= 1'b0;
         retired_r   <= 16'h0000;
         halt_lat_r  <= 1'b0;
         jump_lat_r  <= 1'b0;
         jaddr_lat_r <= 8'h00;
         step_mode_r <= 1'b0;
         prev_run_r  <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         phase_r    <= phase_of(next_state_s);
         running_r  <= (next_state_s != S_IDLE);
         prev_run_r <= bus.RUN;
         case (state_r)
            S_IDLE: begin
               if (start_s) begin
                  halted_r    <= 1'b0;
                  step_mode_r <= ~bus.RUN;
               end
            end
            S_EX: begin
               halt_lat_r  <= bus.HALT_REQ;
               jump_lat_r  <= bus.JUMP_EN;
               jaddr_lat_r <= bus.JUMP_ADDR;
            end
            S_WB: begin
               pc_r        <= jump_lat_r ? jaddr_lat_r : (pc_r + 8'd1);
               retired_r   <= (retired_r == 16'hFFFF) ? 16'hFFFF : (retired_r + 16'd1);
               halted_r    <= halted_r | halt_lat_r;
               halt_lat_r  <= 1'b0;
               jump_lat_r  <= 1'b0;
               jaddr_lat_r <= 8'h00;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.PH_FT   = phase_r[0];
   assign bus.PH_DC   = phase_r[1];
   assign bus.PH_EX   = phase_r[2];
   assign bus.PH_WB   = phase_r[3];
   assign bus.P_COUNT = pc_r;
   assign bus.RUNNING = running_r;
   assign bus.HALTED  = halted_r;
   assign bus.RETIRED = retired_r;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations plus a randomized run against a cycle-level behavioural model.
module tb_pc_sequencer;
   logic CLK;
   logic RESET_N;
   pc_sequencer_if bus();

   pc_sequencer dut (
      .CLK    (CLK),
      .RESET_N(RESET_N),
      .bus    (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks;
   int failures;

   // behavioural model: m_phase is the cycle within the instruction (0 = idle, 1..4 = FT..WB)
   int m_phase;
   int m_pc;
   int m_retired;
   bit m_halted;
   bit m_prev_run;
   bit m_step;
   bit m_halt;
   bit m_jump;
   int m_jaddr;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_pc = 0; m_retired = 0; m_halted = 0;
      m_prev_run = 0; m_step = 0; m_halt = 0; m_jump = 0; m_jaddr = 0;
   endtask

   task automatic model_step();
      bit rise;
      rise = bus.RUN && !m_prev_run;
      if (m_phase == 0) begin
         if (m_halted ? rise : (bus.RUN || bus.STEP)) begin
            m_halted = 0;
            m_step   = !bus.RUN;
            m_phase  = 1;
         end
      end else if (m_phase == 3) begin
         m_halt  = bus.HALT_REQ;
         m_jump  = bus.JUMP_EN;
         m_jaddr = int'(bus.JUMP_ADDR);
         m_phase = 4;
      end else if (m_phase == 4) begin
         m_pc      = m_jump ? m_jaddr : (m_pc + 1) % 256;
         m_retired = (m_retired >= 65535) ? 65535 : m_retired + 1;
         if (m_halt) m_halted = 1;
         m_phase   = (m_halt || m_step || !bus.RUN) ? 0 : 1;
         m_halt    = 0;
         m_jump    = 0;
      end else begin
         m_phase = m_phase + 1;
      end
      m_prev_run = bus.RUN;
   endtask

   task automatic compare_all();
      chk("ph_ft",   int'(bus.PH_FT),   int'(m_phase == 1));
      chk("ph_dc",   int'(bus.PH_DC),   int'(m_phase == 2));
      chk("ph_ex",   int'(bus.PH_EX),   int'(m_phase == 3));
      chk("ph_wb",   int'(bus.PH_WB),   int'(m_phase == 4));
      chk("p_count", int'(bus.P_COUNT), m_pc);
      chk("running", int'(bus.RUNNING), int'(m_phase != 0));
      chk("halted",  int'(bus.HALTED),  int'(m_halted));
      chk("retired", int'(bus.RETIRED), m_retired);
   endtask

   task automatic step_cycle();
      @(posedge CLK);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic clear_inputs();
      bus.RUN = 1'b0; bus.STEP = 1'b0; bus.HALT_REQ = 1'b0;
      bus.JUMP_EN = 1'b0; bus.JUMP_ADDR = 8'h00;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET_N = 1'b0;
      model_reset();
      #1;
      compare_all();
      @(negedge CLK);
      RESET_N = 1'b1;
   endtask

   int   ft_seq[$];
   int   exp_seq[6];
   logic en;

   initial begin
      checks = 0; failures = 0;
      clear_inputs();
      RESET_N = 1'b0;
      model_reset();
      #2;
      chk("reset_pc", int'(bus.P_COUNT), 0);
      chk("reset_retired", int'(bus.RETIRED), 0);
      chk("reset_running", int'(bus.RUNNING), 0);
      @(negedge CLK);
      RESET_N = 1'b1;

      // free-run
      bus.RUN = 1'b1;
      for (int i = 0; i < 41; i++) step_cycle();
      chk("free_retired", int'(bus.RETIRED), 10);
      chk("free_pc", int'(bus.P_COUNT), 10);
      chk("free_ft", int'(bus.PH_FT), 1);
      bus.RUN = 1'b0;
      for (int i = 0; i < 5; i++) step_cycle();
      chk("free_stop_idle", int'(bus.RUNNING), 0);
      chk("free_stop_retired", int'(bus.RETIRED), 11);

      // single step, with a stray STEP during DC
      do_reset();
      clear_inputs();
      for (int k = 0; k < 3; k++) begin
         bus.STEP = 1'b1; step_cycle();
         bus.STEP = 1'b0; step_cycle();
         if (k == 0) bus.STEP = 1'b1;
         step_cycle();
         bus.STEP = 1'b0;
         for (int i = 0; i < 7; i++) step_cycle();
      end
      chk("step_pc", int'(bus.P_COUNT), 3);
      chk("step_retired", int'(bus.RETIRED), 3);
      chk("step_idle", int'(bus.RUNNING), 0);

      // jump with PC wrap
      do_reset();
      clear_inputs();
      bus.RUN = 1'b1;
      bus.JUMP_ADDR = 8'hFE;
      for (int i = 0; i < 24; i++) begin
         bus.JUMP_EN = (m_phase == 3 && m_pc == 2);
         step_cycle();
         if (bus.PH_FT) ft_seq.push_back(int'(bus.P_COUNT));
      end
      bus.JUMP_EN = 1'b0;
      exp_seq = '{0, 1, 2, 254, 255, 0};
      chk("jump_seq_len", ft_seq.size(), 6);
      for (int i = 0; i < 6; i++)
         chk("jump_seq", (i < ft_seq.size()) ? ft_seq[i] : -1, exp_seq[i]);

      // halt with RUN held, then recovery by RUN 1->0->1
      do_reset();
      clear_inputs();
      bus.RUN = 1'b1;
      for (int i = 0; i < 60; i++) begin
         bus.HALT_REQ = (m_phase == 3 && m_pc == 5);
         step_cycle();
         if (m_halted && m_phase == 0) break;
      end
      bus.HALT_REQ = 1'b0;
      chk("halt_pc", int'(bus.P_COUNT), 6);
      chk("halt_flag", int'(bus.HALTED), 1);
      chk("halt_idle", int'(bus.RUNNING), 0);
      step_cycle();
      chk("halt_run_level_ignored", int'(bus.RUNNING), 0);
      bus.STEP = 1'b1; step_cycle();
      bus.STEP = 1'b0; step_cycle();
      chk("halt_step_ignored", int'(bus.RUNNING), 0);
      bus.RUN = 1'b0; step_cycle();
      bus.RUN = 1'b1; step_cycle();
      chk("resume_ft", int'(bus.PH_FT), 1);
      chk("resume_halted", int'(bus.HALTED), 0);
      chk("resume_pc", int'(bus.P_COUNT), 6);

      // jump and halt in the same instruction
      do_reset();
      clear_inputs();
      bus.RUN = 1'b1;
      bus.JUMP_ADDR = 8'h40;
      for (int i = 0; i < 40; i++) begin
         en = (m_phase == 3 && m_pc == 1);
         bus.JUMP_EN = en;
         bus.HALT_REQ = en;
         step_cycle();
         if (m_halted && m_phase == 0) break;
      end
      clear_inputs();
      bus.RUN = 1'b1;
      chk("jh_pc", int'(bus.P_COUNT), 64);
      chk("jh_halted", int'(bus.HALTED), 1);

      // asynchronous reset during EX at PC=7
      do_reset();
      clear_inputs();
      bus.RUN = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step_cycle();
         if (m_phase == 3 && m_pc == 7) break;
      end
      chk("pre_reset_ex", int'(bus.PH_EX), 1);
      #2;
      RESET_N = 1'b0;
      model_reset();
      #1;
      chk("areset_ex", int'(bus.PH_EX), 0);
      chk("areset_pc", int'(bus.P_COUNT), 0);
      chk("areset_retired", int'(bus.RETIRED), 0);
      chk("areset_running", int'(bus.RUNNING), 0);
      compare_all();
      @(negedge CLK);
      RESET_N = 1'b1;
      step_cycle();
      chk("restart_ft", int'(bus.PH_FT), 1);
      chk("restart_pc", int'(bus.P_COUNT), 0);

      // randomized traffic against the model
      do_reset();
      clear_inputs();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(15) == 0) bus.RUN = ~bus.RUN;
         bus.STEP      = ($urandom_range(7) == 0);
         bus.HALT_REQ  = ($urandom_range(11) == 0);
         bus.JUMP_EN   = ($urandom_range(3) == 0);
         bus.JUMP_ADDR = 8'($urandom_range(255));
         step_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset. Ports are CLK (clock, rising edge) and RESET_N (async, active-low).
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 RESET_N  in  1  asynchronous active-low reset.
REQ-004 RUN  in  1  level; 1 = free-run, fetch instructions back to back.
REQ-005 STEP  in  1  single-cycle pulse; run exactly one instruction while idle.
REQ-006 HALT_REQ  in  1  halt instruction indication, sampled only in EX phase.
REQ-007 JUMP_EN  in  1  branch taken, sampled only in EX phase.
REQ-008 JUMP_ADDR  in  8  branch target, sampled with JUMP_EN.
REQ-009 PH_FT, PH_DC, PH_EX, PH_WB  out  1 each  one-hot phase strobes, registered.
REQ-010 P_COUNT  out  8  program counter driving the fetch ROM address.
REQ-011 RUNNING  out  1  1 whenever state != IDLE.
REQ-012 HALTED  out  1  sticky halt flag.
REQ-013 RETIRED  out  16  count of completed instructions.

Function
REQ-014 States SHALL be IDLE, FT, DC, EX, WB. PH_x = 1 exactly while in state x. All strobes are 0 in IDLE.
REQ-015 FT->DC->EX->WB SHALL each take exactly one cycle, giving 4 cycles per instruction.
REQ-016 IDLE->FT SHALL occur when HALTED=0 and (RUN=1 or STEP=1). PH_FT rises the cycle after the input is sampled.
REQ-017 STEP SHALL be ignored outside IDLE. STEP=1 with RUN=1 in IDLE SHALL start one normal free-run instruction.
REQ-018 An instruction started by STEP alone (RUN=0) SHALL be marked step-mode. At its WB the state returns to IDLE regardless of RUN.
REQ-019 At WB SHALL go: HALT latched -> IDLE; else step-mode -> IDLE; else RUN=1 -> FT (no bubble); else IDLE.
REQ-020 HALT_REQ, JUMP_EN and JUMP_ADDR SHALL be registered during EX only. Their values in other phases are ignored.
REQ-021 P_COUNT SHALL update only on the WB->next edge: JUMP latched ? JUMP_ADDR latched : P_COUNT+1, modulo 256 (255 -> 0).
REQ-022 P_COUNT SHALL be stable from FT through WB of each instruction.
REQ-023 Jump and halt in the same instruction SHALL load the jump target into P_COUNT, then set HALTED.
REQ-024 HALTED SHALL be set on the WB edge of a halting instruction.
REQ-025 HALTED SHALL be cleared only by a RUN 0->1 transition detected while in IDLE (registered previous RUN). That same transition starts FT the next cycle.
REQ-026 While HALTED=1, RUN held at level 1 and STEP SHALL NOT start fetches.
REQ-027 RETIRED SHALL increment by 1 on each WB edge and saturate at 0xFFFF.
REQ-028 Latched EX flags SHALL clear after WB, so no jump or halt leaks into the next instruction.

Reset
REQ-029 When RESET_N=0 the block SHALL immediately, asynchronously, set:
- state=IDLE
- P_COUNT=0x00
- all PH_* = 0
- RUNNING=0
- HALTED=0
- RETIRED=0x0000
- latched flags=0
- registered previous RUN=0
REQ-030 Reset asserted mid-instruction SHALL abort it with no PC or RETIRED update. After release, RUN=1 restarts at FT with P_COUNT=0. Because previous RUN resets to 0, this counts as a rising edge.

Verification
REQ-031 Free-run: reset, RUN=1 for 40 cycles -> PH_FT/DC/EX/WB rotate every 4 cycles with no gaps; P_COUNT 0,1,2,...,9; RETIRED=10.
REQ-032 Step: RUN=0, three STEP pulses spaced 10 cycles apart -> three 4-cycle bursts, IDLE between them; P_COUNT ends at 3; STEP pulsed during DC is ignored.
REQ-033 Jump/wrap: free-run, JUMP_EN=1 with JUMP_ADDR=0xFE in EX of instr 2 -> P_COUNT sequence 0,1,2,0xFE,0xFF,0x00.
REQ-034 Halt: HALT_REQ=1 in EX at P_COUNT=5 with RUN held at 1 -> P_COUNT=6, HALTED=1, IDLE; STEP ignored; RUN 1->0->1 -> HALTED=0 and PH_FT at P_COUNT=6.
REQ-035 Jump and halt together: JUMP_ADDR=0x40 plus HALT_REQ in the same EX -> P_COUNT=0x40, HALTED=1.
REQ-036 Async reset in EX at P_COUNT=7 -> all outputs reset immediately without waiting for a clock edge; RETIRED is not incremented.
